// File: rtl/result_frame_rx_if.sv
// Result-link receiver bus: byte stream, frame/error strobes, read-bank port and peak report.
interface result_frame_rx_if #(
  parameter int NBYTES = 8
);
  localparam int IW = $clog2(NBYTES);

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          frame_valid;
  logic [IW-1:0] rd_idx;
  logic [7:0]    rd_data;
  logic          frame_err;
  logic [7:0]    err_count;
  logic [IW-1:0] peak_idx;
  logic [7:0]    peak_val;

  modport master (
    output byte_valid, byte_data, frame_valid, rd_data, frame_err, err_count, peak_idx, peak_val,
    input  rd_idx
  );

  modport slave (
    input  byte_valid, byte_data, frame_valid, rd_data, frame_err, err_count, peak_idx, peak_val,
    output rd_idx
  );
endinterface

// File: rtl/result_frame_rx.sv
// Correlator result link receiver: 8N1 UART, idle-gap framing, double-buffered frame bank.
// Optional FRAME_PEAK_EN adds a running argmax reported with each accepted frame.
module result_frame_rx #(
  parameter int CLK_FREQ = 48000000,
  parameter int SYM_RATE = 1200,
  parameter int NBYTES   = 8,
  parameter int GAP_SYMS = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_serial,
  result_frame_rx_if.master bus
);
  localparam int SYM_CNT = CLK_FREQ / SYM_RATE;
  localparam int SCW     = $clog2(SYM_CNT);
  localparam int IW      = $clog2(NBYTES);
  localparam int GAP     = GAP_SYMS * SYM_CNT;
  localparam int GW      = $clog2(GAP + 1);

  localparam logic [SCW-1:0] HALF_M1 = SCW'(SYM_CNT / 2 - 1);
  localparam logic [SCW-1:0] FULL_M1 = SCW'(SYM_CNT - 1);
  localparam logic [GW-1:0]  GAP_M1  = GW'(GAP - 1);
  localparam logic [GW-1:0]  GAP_MAX = GW'(GAP);
  localparam logic [IW-1:0]  LAST    = IW'(NBYTES - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic {F_HUNT, F_COLLECT} fr_state_t;

  rx_state_t     rx_state;
  fr_state_t     fr_state;
  logic          rx_meta, rx_sync, rx_prev;
  logic [SCW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          byte_valid_r, stop_err;
  logic [7:0]    byte_data_r;
  logic [GW-1:0] gap_cnt;
  logic          gap_reach, store, last_byte;
  logic [IW-1:0] wr_ptr;
  logic [7:0]    wbuf [NBYTES];
  logic [7:0]    bank [NBYTES];
  logic          frame_valid_r, frame_err_r;
  logic [7:0]    err_cnt, rd_data_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state     <= RX_IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      byte_valid_r <= 1'b0;
      byte_data_r  <= '0;
      stop_err     <= 1'b0;
    end else begin
      byte_valid_r <= 1'b0;
      stop_err     <= 1'b0;
      case (rx_state)
        RX_IDLE:
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            cnt      <= HALF_M1;
          end
        RX_START:
          if (cnt == '0) begin
            if (rx_sync) rx_state <= RX_IDLE;
            else begin
              rx_state <= RX_DATA;
              cnt      <= FULL_M1;
              bit_cnt  <= '0;
            end
          end else cnt <= cnt - 1'b1;
        RX_DATA:
          if (cnt == '0) begin
            shreg   <= {rx_sync, shreg[7:1]};
            cnt     <= FULL_M1;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) rx_state <= RX_STOP;
          end else cnt <= cnt - 1'b1;
        RX_STOP:
          if (cnt == '0) begin
            if (rx_sync) begin
              byte_valid_r <= 1'b1;
              byte_data_r  <= shreg;
              rx_state     <= RX_IDLE;
            end else begin
              stop_err <= 1'b1;
              rx_state <= RX_BREAK;
            end
          end else cnt <= cnt - 1'b1;
        RX_BREAK:
          if (rx_sync) rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // gap_reach is a single-cycle event on the transition into GAP, not a level
  assign gap_reach = (rx_state == RX_IDLE) && rx_sync && (gap_cnt == GAP_M1);
  assign store     = (fr_state == F_COLLECT) && byte_valid_r;
  assign last_byte = (wr_ptr == LAST);

  always_ff @(posedge clk) begin
    if (rst) gap_cnt <= '0;
    else if (rx_state == RX_IDLE && rx_sync) begin
      if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + 1'b1;
    end else gap_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fr_state      <= F_HUNT;
      wr_ptr        <= '0;
      frame_valid_r <= 1'b0;
      frame_err_r   <= 1'b0;
      err_cnt       <= '0;
      for (int unsigned i = 0; i < NBYTES; i++) begin
        wbuf[i] <= '0;
        bank[i] <= '0;
      end
    end else begin
      frame_valid_r <= 1'b0;
      frame_err_r   <= 1'b0;
      if (stop_err) begin
        frame_err_r <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
        fr_state <= F_HUNT;
        wr_ptr   <= '0;
      end else if (fr_state == F_HUNT) begin
        if (gap_reach) begin
          fr_state <= F_COLLECT;
          wr_ptr   <= '0;
        end
      end else if (store) begin
        wbuf[wr_ptr] <= byte_data_r;
        if (last_byte) begin
          // last byte bypasses wbuf so the bank holds the whole frame in the frame_valid cycle
          for (int unsigned i = 0; i < NBYTES; i++)
            bank[i] <= (IW'(i) == wr_ptr) ? byte_data_r : wbuf[i];
          frame_valid_r <= 1'b1;
          wr_ptr        <= '0;
        end else wr_ptr <= wr_ptr + 1'b1;
      end else if (gap_reach && wr_ptr != '0) begin
        frame_err_r <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
        wr_ptr <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_r <= '0;
    else if (int'(bus.rd_idx) < NBYTES) rd_data_r <= bank[bus.rd_idx];
    else rd_data_r <= '0;
  end

`ifdef FRAME_PEAK_EN
  logic [IW-1:0] run_idx, pk_idx, nxt_idx;
  logic [7:0]    run_val, pk_val, nxt_val;
  logic          take;

  always_comb begin
    take    = (wr_ptr == '0) || (byte_data_r > run_val);
    nxt_idx = take ? wr_ptr : run_idx;
    nxt_val = take ? byte_data_r : run_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_idx <= '0;
      run_val <= '0;
      pk_idx  <= '0;
      pk_val  <= '0;
    end else if (store && !stop_err) begin
      run_idx <= nxt_idx;
      run_val <= nxt_val;
      if (last_byte) begin
        pk_idx <= nxt_idx;
        pk_val <= nxt_val;
      end
    end
  end

  assign bus.peak_idx = pk_idx;
  assign bus.peak_val = pk_val;
`else
  assign bus.peak_idx = '0;
  assign bus.peak_val = '0;
`endif

  assign bus.byte_valid  = byte_valid_r;
  assign bus.byte_data   = byte_data_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.frame_err   = frame_err_r;
  assign bus.err_count   = err_cnt;
  assign bus.rd_data     = rd_data_r;
endmodule

// File: tb/tb_result_frame_rx.sv
// Scoreboard bench for result_frame_rx: stimulus pushes expected bytes/frames/errors, a negedge monitor pops and compares.
module tb_result_frame_rx;
  localparam int BIT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_serial = 1'b1;

  result_frame_rx_if #(.NBYTES(8)) bus ();

  result_frame_rx #(
    .CLK_FREQ(160000),
    .SYM_RATE(10000),
    .NBYTES  (8),
    .GAP_SYMS(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_serial(rx_serial),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  exp_bytes  [$];
  logic [10:0] exp_frames [$];
  logic [7:0]  exp_errs   [$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  err_model = 8'd0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic unexpected(input string nm, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h required=none", nm, act);
  endtask

  // Peak outputs are only meaningful when the design is built with the peak feature.
  function automatic logic [10:0] pk(input logic [2:0] idx, input logic [7:0] val);
`ifdef FRAME_PEAK_EN
    return {idx, val};
`else
    return {idx, val} & 11'h000;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.byte_valid) begin
        if (exp_bytes.size() == 0) unexpected("byte_valid", {56'd0, bus.byte_data});
        else check("byte_data", {56'd0, bus.byte_data}, {56'd0, exp_bytes.pop_front()});
      end
      if (bus.frame_valid) begin
        if (exp_frames.size() == 0) unexpected("frame_valid", {53'd0, bus.peak_idx, bus.peak_val});
        else check("peak", {53'd0, bus.peak_idx, bus.peak_val}, {53'd0, exp_frames.pop_front()});
      end
      if (bus.frame_err) begin
        if (exp_errs.size() == 0) unexpected("frame_err", {56'd0, bus.err_count});
        else check("err_count_at_err", {56'd0, bus.err_count}, {56'd0, exp_errs.pop_front()});
      end
    end
  end

  task automatic idle(input int n);
    rx_serial = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_ok);
    if (stop_ok) exp_bytes.push_back(d);
    rx_serial = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      rx_serial = d[b];
      repeat (BIT) @(negedge clk);
    end
    rx_serial = stop_ok;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [63:0] f, input logic [2:0] pi, input logic [7:0] pv,
                            input logic expect_frame);
    if (expect_frame) exp_frames.push_back(pk(pi, pv));
    for (int i = 0; i < 8; i++) send_byte(f[8*i +: 8], 1'b1);
  endtask

  task automatic push_err();
    if (err_model != 8'hFF) err_model = err_model + 8'd1;
    exp_errs.push_back(err_model);
  endtask

  task automatic check_bank(input logic [63:0] f);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.rd_idx = i[2:0];
      @(negedge clk);
      check("rd_data", {56'd0, bus.rd_data}, {56'd0, f[8*i +: 8]});
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    check(nm, {26'd0, bus.byte_valid, bus.byte_data, bus.frame_valid, bus.frame_err,
               bus.err_count, bus.peak_idx, bus.peak_val, bus.rd_data}, 64'd0);
  endtask

  localparam logic [63:0] F1 = 64'h7766554433221100;
  localparam logic [63:0] F3 = 64'h000000F0F010F010;
  localparam logic [63:0] FA = 64'h3C3C3C3C3C3C3C3C;
  localparam logic [63:0] FB = 64'h01FF00FF03090905;
  localparam logic [63:0] F6 = 64'hF0DEBC9A78FE3412;

  initial begin
    bus.rd_idx = 3'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;

    // 1: clean frame after initial gap
    idle(100);
    send_frame(F1, 3'd7, 8'h77, 1'b1);
    idle(20);
    check_bank(F1);

    // 2: short frame ended by gap
    push_err();
    for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i), 1'b1);
    idle(80);
    check("err_count_short", {56'd0, bus.err_count}, 64'd1);
    check_bank(F1);

    // 3: stop-bit error, recovery, frame with tied maxima
    push_err();
    send_byte(8'hA5, 1'b0);
    idle(80);
    send_frame(F3, 3'd1, 8'hF0, 1'b1);
    idle(20);
    check_bank(F3);

    // 4: glitch restarts the gap timer, so the frame stays in HUNT
    push_err();
    send_byte(8'hA5, 1'b0);
    idle(40);
    rx_serial = 1'b0;
    repeat (6) @(negedge clk);
    idle(40);
    send_frame(64'h0123456789ABCDEF, 3'd0, 8'h00, 1'b0);
    idle(100);
    check("err_count_glitch", {56'd0, bus.err_count}, 64'd3);
    check_bank(F3);

    // 5: two frames separated by exactly one gap
    send_frame(FA, 3'd0, 8'h3C, 1'b1);
    idle(64);
    send_frame(FB, 3'd4, 8'hFF, 1'b1);
    idle(20);
    check_bank(FB);

    // 6: reset during the fifth byte
    for (int i = 0; i < 4; i++) send_byte(8'h01 + 8'(i), 1'b1);
    rx_serial = 1'b0;
    repeat (BIT) @(negedge clk);
    rx_serial = 1'b1; repeat (BIT) @(negedge clk);
    rx_serial = 1'b0; repeat (BIT) @(negedge clk);
    rx_serial = 1'b1; repeat (BIT) @(negedge clk);
    rst = 1'b1;
    bus.rd_idx = 3'd2;
    repeat (2) @(negedge clk);
    check_reset_outputs("midop_reset");
    err_model = 8'd0;
    rst = 1'b0;
    @(negedge clk);
    check("bank_cleared", {56'd0, bus.rd_data}, 64'd0);
    idle(100);
    send_frame(F6, 3'd2, 8'hFE, 1'b1);
    idle(20);
    check_bank(F6);

    // error counter saturation
    for (int n = 0; n < 260; n++) begin
      push_err();
      send_byte(8'h5A, 1'b1);
      idle(70);
    end
    check("err_count_sat", {56'd0, bus.err_count}, 64'd255);

    for (int t = 0; t < 1000; t++) begin
      if (exp_bytes.size() == 0 && exp_frames.size() == 0 && exp_errs.size() == 0) break;
      @(negedge clk);
    end
    check("pending_bytes",  exp_bytes.size(),  64'd0);
    check("pending_frames", exp_frames.size(), 64'd0);
    check("pending_errs",   exp_errs.size(),   64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end
endmodule
